// File: rtl/ssp_uart_ctrl.sv
// SSP master sequencer for the SSP_UART register port: arbitrates host and poll
// requesters round-robin and serialises one 16-bit read/write frame at a time.
module ssp_uart_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int GAP_BITS = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        H_Req,
    input  logic [2:0]  H_RA,
    input  logic        H_WnR,
    input  logic [11:0] H_DI,
    output logic        H_Ack,
    output logic [11:0] H_DO,
    input  logic        P_Req,
    input  logic [2:0]  P_RA,
    input  logic        P_WnR,
    input  logic [11:0] P_DI,
    output logic        P_Ack,
    output logic [11:0] P_DO,
    input  logic [11:0] SSP_DO,
    output logic        SSP_SSEL,
    output logic        SSP_SCK,
    output logic [2:0]  SSP_RA,
    output logic        SSP_WnR,
    output logic        SSP_En,
    output logic        SSP_EOC,
    output logic [11:0] SSP_DI,
    output logic        Busy,
    output logic [2:0]  Dbg_State
);

    localparam int DW      = $clog2(CLK_DIV) + 1;
    localparam int GAP_CYC = GAP_BITS * 2 * CLK_DIV;
    localparam int GW      = $clog2(GAP_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HDR  = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          half_q, half_d;
    logic [3:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          gnt_q, gnt_d;
    logic          rr_q, rr_d;
    logic          fresh_q, fresh_d;
    logic [2:0]    ra_q, ra_d;
    logic          wnr_q, wnr_d;
    logic [11:0]   di_q, di_d;
    logic [11:0]   samp_q, samp_d;
    logic [11:0]   hdo_q, hdo_d;
    logic [11:0]   pdo_q, pdo_d;

    logic half_end;
    logic bit_end;
    logic win_p;

    // gnt/rr encode the requester: 0 = host, 1 = poll.  fresh_q makes the
    // first contested grant after reset go to the host.
    always_comb begin
        half_end = (div_q == DW'(CLK_DIV - 1));
        bit_end  = half_end && half_q;
        if (H_Req && P_Req) begin
            win_p = fresh_q ? 1'b0 : ~rr_q;
        end else begin
            win_p = P_Req;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        fresh_d = fresh_q;
        ra_d    = ra_q;
        wnr_d   = wnr_q;
        di_d    = di_q;
        samp_d  = samp_q;
        hdo_d   = hdo_q;
        pdo_d   = pdo_q;
        case (state_q)
            S_IDLE: begin
                if (H_Req || P_Req) begin
                    gnt_d   = win_p;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ra_d    = gnt_q ? P_RA : H_RA;
                wnr_d   = gnt_q ? P_WnR : H_WnR;
                di_d    = (gnt_q ? P_WnR : H_WnR) ? (gnt_q ? P_DI : H_DI) : 12'd0;
                bit_d   = 4'd15;
                div_d   = '0;
                half_d  = 1'b0;
                state_d = S_HDR;
            end
            S_HDR, S_DATA: begin
                if (half_end) begin
                    div_d  = '0;
                    half_d = ~half_q;
                end else begin
                    div_d = div_q + DW'(1);
                end
                // Slave data is taken on the rising SCK of the last bit.
                if (state_q == S_DATA && bit_q == 4'd0 && half_end && !half_q) begin
                    samp_d = SSP_DO;
                end
                if (bit_end) begin
                    if (bit_q == 4'd0) begin
                        state_d = S_DONE;
                        if (!wnr_q) begin
                            if (gnt_q) begin
                                pdo_d = samp_q;
                            end else begin
                                hdo_d = samp_q;
                            end
                        end
                    end else begin
                        bit_d = bit_q - 4'd1;
                        if (bit_q == 4'd12) begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DONE: begin
                rr_d    = gnt_q;
                fresh_d = 1'b0;
                ra_d    = 3'd0;
                wnr_d   = 1'b0;
                di_d    = 12'd0;
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            half_q  <= 1'b0;
            bit_q   <= 4'd0;
            gap_q   <= '0;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
            fresh_q <= 1'b1;
            ra_q    <= 3'd0;
            wnr_q   <= 1'b0;
            di_q    <= 12'd0;
            samp_q  <= 12'd0;
            hdo_q   <= 12'd0;
            pdo_q   <= 12'd0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            fresh_q <= fresh_d;
            ra_q    <= ra_d;
            wnr_q   <= wnr_d;
            di_q    <= di_d;
            samp_q  <= samp_d;
            hdo_q   <= hdo_d;
            pdo_q   <= pdo_d;
        end
    end

    // Frame outputs decode straight from the state register so they drop with Rst.
    assign SSP_SSEL  = (state_q == S_HDR) || (state_q == S_DATA);
    assign SSP_SCK   = SSP_SSEL && half_q;
    assign SSP_En    = (state_q == S_DATA);
    assign SSP_EOC   = (state_q == S_DATA) && (bit_q == 4'd0);
    assign SSP_RA    = ra_q;
    assign SSP_WnR   = wnr_q;
    assign SSP_DI    = di_q;
    assign Busy      = (state_q != S_IDLE);
    assign H_Ack     = (state_q == S_DONE) && !gnt_q;
    assign P_Ack     = (state_q == S_DONE) && gnt_q;
    assign H_DO      = hdo_q;
    assign P_DO      = pdo_q;
    assign Dbg_State = state_q;

endmodule

// File: tb/tb_ssp_uart_ctrl.sv
// Randomized host/poll traffic against a frame-level reference model, for
// CLK_DIV=2/GAP_BITS=1 and CLK_DIV=1/GAP_BITS=3 instances, plus a mid-frame reset.
module tb_ssp_uart_ctrl;

    localparam int D0 = 2;
    localparam int G0 = 1;
    localparam int D1 = 1;
    localparam int G1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        req_v [2];
    logic [2:0]  ra_v  [2];
    logic        wnr_v [2];
    logic [11:0] di_v  [2];
    logic [11:0] ssp_do;

    logic        h_ack0, p_ack0, ssel0, sck0, wnr0, en0, eoc0, busy0;
    logic [11:0] h_do0, p_do0, di0;
    logic [2:0]  ra0, st0;
    logic        h_ack1, p_ack1, ssel1, sck1, wnr1, en1, eoc1, busy1;
    logic [11:0] h_do1, p_do1, di1;
    logic [2:0]  ra1, st1;

    ssp_uart_ctrl #(.CLK_DIV(D0), .GAP_BITS(G0)) dut0 (
        .Clk(clk), .Rst(rst),
        .H_Req(req_v[0] & ~sel), .H_RA(ra_v[0]), .H_WnR(wnr_v[0]), .H_DI(di_v[0]),
        .H_Ack(h_ack0), .H_DO(h_do0),
        .P_Req(req_v[1] & ~sel), .P_RA(ra_v[1]), .P_WnR(wnr_v[1]), .P_DI(di_v[1]),
        .P_Ack(p_ack0), .P_DO(p_do0),
        .SSP_DO(ssp_do), .SSP_SSEL(ssel0), .SSP_SCK(sck0), .SSP_RA(ra0), .SSP_WnR(wnr0),
        .SSP_En(en0), .SSP_EOC(eoc0), .SSP_DI(di0), .Busy(busy0), .Dbg_State(st0)
    );

    ssp_uart_ctrl #(.CLK_DIV(D1), .GAP_BITS(G1)) dut1 (
        .Clk(clk), .Rst(rst),
        .H_Req(req_v[0] & sel), .H_RA(ra_v[0]), .H_WnR(wnr_v[0]), .H_DI(di_v[0]),
        .H_Ack(h_ack1), .H_DO(h_do1),
        .P_Req(req_v[1] & sel), .P_RA(ra_v[1]), .P_WnR(wnr_v[1]), .P_DI(di_v[1]),
        .P_Ack(p_ack1), .P_DO(p_do1),
        .SSP_DO(ssp_do), .SSP_SSEL(ssel1), .SSP_SCK(sck1), .SSP_RA(ra1), .SSP_WnR(wnr1),
        .SSP_En(en1), .SSP_EOC(eoc1), .SSP_DI(di1), .Busy(busy1), .Dbg_State(st1)
    );

    logic        m_hack, m_pack, m_ssel, m_sck, m_wnr, m_en, m_eoc, m_busy;
    logic [11:0] m_hdo, m_pdo, m_di;
    logic [2:0]  m_ra;
    assign m_hack = sel ? h_ack1 : h_ack0;
    assign m_pack = sel ? p_ack1 : p_ack0;
    assign m_ssel = sel ? ssel1  : ssel0;
    assign m_sck  = sel ? sck1   : sck0;
    assign m_wnr  = sel ? wnr1   : wnr0;
    assign m_en   = sel ? en1    : en0;
    assign m_eoc  = sel ? eoc1   : eoc0;
    assign m_busy = sel ? busy1  : busy0;
    assign m_hdo  = sel ? h_do1  : h_do0;
    assign m_pdo  = sel ? p_do1  : p_do0;
    assign m_di   = sel ? di1    : di0;
    assign m_ra   = sel ? ra1    : ra0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [12:0] exp_q[$];
    logic [1:0]  req_hist  [0:4095];
    logic        busy_hist [0:4095];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) req_v[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Each requester issues nf random frames; the model predicts the winner,
    // bus fields, bit-time shape, Ack timing and returned read data.
    task automatic run_phase(input int nf);
        int n, s, ack_n, dd, gc, k, win, idle_c;
        int left[2], idle_cd[2], wait_c[2];
        int ssel_c, en_c, eoc_c, shape_e, hold_e, busy_e, idle_e, spur_e;
        bit in_frame, a_valid, last_valid, last_p, timeout, done_now;
        logic [11:0] rd_val, h_exp, p_exp, f_di;
        logic [2:0]  f_ra;
        logic        f_wnr;
        logic [1:0]  r;
        logic [12:0] e;
        dd = sel ? D1 : D0;
        gc = sel ? (G1 * 2 * D1) : (G0 * 2 * D0);
        h_exp = 12'd0;  p_exp = 12'd0;  rd_val = 12'd0;
        f_ra = 3'd0;  f_wnr = 1'b0;  f_di = 12'd0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            left[i] = nf;  idle_cd[i] = 0;  wait_c[i] = 0;  req_v[i] = 1'b0;
        end
        n = 0;  s = 0;  ack_n = 0;  win = 0;
        ssel_c = 0;  en_c = 0;  eoc_c = 0;  shape_e = 0;  hold_e = 0;
        busy_e = 0;  idle_e = 0;  spur_e = 0;
        in_frame = 0;  a_valid = 0;  last_valid = 0;  last_p = 0;  timeout = 0;
        while ((left[0] > 0 || left[1] > 0 || in_frame) && !timeout) begin
            @(negedge clk);
            done_now = 0;
            if (m_ssel && !in_frame) begin
                in_frame = 1;  s = n;
                ssel_c = 0;  en_c = 0;  eoc_c = 0;  shape_e = 0;  hold_e = 0;
                win = 0;
                if (s < 2) begin
                    check("grant_early", 32'(s), 32'd2);
                end else begin
                    r = req_hist[s-2];
                    if (r == 2'b11)      win = (last_valid && !last_p) ? 1 : 0;
                    else if (r == 2'b10) win = 1;
                    else if (r == 2'b00) check("grant_without_req", 32'(r), 32'd1);
                    if (busy_hist[s-2] || !busy_hist[s-1]) busy_e++;
                end
                if (a_valid) begin
                    idle_c = ack_n + gc + 1;
                    if (idle_c >= n) check("gap_min", 32'(s - ack_n), 32'(gc + 3));
                    else if (req_hist[idle_c] != 2'b00) check("gap_exact", 32'(s - ack_n), 32'(gc + 3));
                    else check("gap_min_ok", 32'(s - ack_n >= gc + 3), 32'd1);
                end
                last_valid = 1;  last_p = (win == 1);
                f_ra  = ra_v[win];
                f_wnr = wnr_v[win];
                f_di  = wnr_v[win] ? di_v[win] : 12'd0;
                check("frame_ra", 32'(m_ra), 32'(f_ra));
                check("frame_wnr", 32'(m_wnr), 32'(f_wnr));
                check("frame_di", 32'(m_di), 32'(f_di));
                rd_val = 12'($urandom_range(0, 4095));
                if (!f_wnr) begin
                    if (win == 1) p_exp = rd_val;
                    else          h_exp = rd_val;
                end
                exp_q.push_back({1'(win), (win == 1) ? p_exp : h_exp});
            end
            if (in_frame) begin
                if (m_ssel) begin
                    k = n - s;
                    ssel_c++;
                    if (m_en)  en_c++;
                    if (m_eoc) eoc_c++;
                    if (m_sck !== ((k % (2 * dd)) >= dd) || m_en !== (k >= 8 * dd) ||
                        m_eoc !== (k >= 30 * dd)) shape_e++;
                    if (m_ra !== f_ra || m_wnr !== f_wnr || m_di !== f_di) hold_e++;
                    if (!m_busy) busy_e++;
                end else begin
                    in_frame = 0;  done_now = 1;
                    check("ssel_cycles", 32'(ssel_c), 32'(32 * dd));
                    check("en_cycles", 32'(en_c), 32'(24 * dd));
                    check("eoc_cycles", 32'(eoc_c), 32'(2 * dd));
                    check("bit_shape", 32'(shape_e), 32'd0);
                    check("field_hold", 32'(hold_e), 32'd0);
                    e = exp_q.pop_front();
                    check("h_ack", 32'(m_hack), 32'(!e[12]));
                    check("p_ack", 32'(m_pack), 32'(e[12]));
                    check("winner_do", 32'(e[12] ? m_pdo : m_hdo), 32'(e[11:0]));
                    check("h_do", 32'(m_hdo), 32'(h_exp));
                    check("p_do", 32'(m_pdo), 32'(p_exp));
                    ack_n = n;  a_valid = 1;
                end
            end else if (m_sck || m_en || m_eoc) begin
                idle_e++;
            end
            if ((m_hack || m_pack) && !done_now) spur_e++;
            if (a_valid && !in_frame && n > ack_n && n <= ack_n + gc && !m_busy) busy_e++;
            if (a_valid && !in_frame && n == ack_n + gc + 1 && m_busy) busy_e++;
            ssp_do = m_eoc ? rd_val : 12'($urandom_range(0, 4095));
            for (int i = 0; i < 2; i++) begin
                if (req_v[i]) begin
                    if ((i == 0 && m_hack) || (i == 1 && m_pack)) begin
                        req_v[i] = 1'b0;
                        left[i]--;
                        idle_cd[i] = $urandom_range(0, 60);
                    end else begin
                        wait_c[i]++;
                        if (wait_c[i] > 600) begin
                            check("req_wait_bound", 32'(wait_c[i]), 32'd600);
                            timeout = 1;
                        end
                    end
                end else if (left[i] > 0) begin
                    if (idle_cd[i] == 0) begin
                        req_v[i]  = 1'b1;
                        ra_v[i]   = 3'($urandom_range(0, 7));
                        wnr_v[i]  = 1'($urandom_range(0, 1));
                        di_v[i]   = 12'($urandom_range(0, 4095));
                        wait_c[i] = 0;
                    end else begin
                        idle_cd[i]--;
                    end
                end
            end
            req_hist[n]  = {req_v[1], req_v[0]};
            busy_hist[n] = m_busy;
            n++;
            if (n >= 4000 && !timeout) begin
                check("phase_cycle_bound", 32'(n), 32'd3999);
                timeout = 1;
            end
        end
        check("busy_profile", 32'(busy_e), 32'd0);
        check("idle_outputs", 32'(idle_e), 32'd0);
        check("spurious_ack", 32'(spur_e), 32'd0);
    endtask

    initial begin
        int k, acks;
        sel = 1'b0;
        ssp_do = 12'd0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0;  ra_v[i] = 3'd0;  wnr_v[i] = 1'b0;  di_v[i] = 12'd0;
        end
        do_reset();
        check("rst_ssel", 32'({ssel0, ssel1}), 32'd0);
        check("rst_sck_en_eoc", 32'({sck0, en0, eoc0, sck1, en1, eoc1}), 32'd0);
        check("rst_busy", 32'({busy0, busy1}), 32'd0);
        check("rst_ack", 32'({h_ack0, p_ack0, h_ack1, p_ack1}), 32'd0);
        check("rst_bus", 32'({ra0, wnr0, di0}), 32'd0);
        check("rst_do", 32'({h_do0, p_do0}), 32'd0);

        run_phase(8);

        // Reset in the middle of DATA bit 5 of a host write.
        do_reset();
        req_v[0] = 1'b1;  ra_v[0] = 3'd3;  wnr_v[0] = 1'b1;  di_v[0] = 12'h5A5;
        k = 0;
        while (!m_en && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rst_test_en_seen", 32'(m_en), 32'd1);
        repeat (2 * D0 * 6) @(negedge clk);
        check("rst_test_in_data", 32'({m_ssel, m_en}), 32'b11);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ssel", 32'(m_ssel), 32'd0);
        check("rst_mid_en_sck", 32'({m_en, m_sck, m_eoc}), 32'd0);
        check("rst_mid_busy", 32'(m_busy), 32'd0);
        @(negedge clk);
        req_v[0] = 1'b0;
        rst = 1'b0;
        acks = 0;
        repeat (100) begin
            @(negedge clk);
            if (m_hack || m_pack) acks++;
        end
        check("rst_mid_no_ack", 32'(acks), 32'd0);
        check("rst_mid_do", 32'({m_hdo, m_pdo}), 32'd0);

        run_phase(4);

        sel = 1'b1;
        do_reset();
        run_phase(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
